// File: rtl/main_fsm_pkg.sv
// Shared encodings for the multicycle control FSM: state enum, mux select
// codes and instruction-class codes.
package main_fsm_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECUTER = 4'd6,
    ST_EXECUTEI = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BRANCH   = 4'd9
  } state_t;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result bus select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Instruction classes carried on Op
  localparam logic [1:0] OP_DP     = 2'b00;
  localparam logic [1:0] OP_MEM    = 2'b01;
  localparam logic [1:0] OP_BRANCH = 2'b10;
  localparam logic [1:0] OP_UNDEF  = 2'b11;

  // True for the states that stall on the memory wait counter
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_MEMREAD) || (s == ST_MEMWRITE);
  endfunction

endpackage

// File: rtl/main_fsm_memwait_counter.sv
// 4-bit memory wait counter: cleared while idle, counts up while a memory
// state is stalling. The controller stops incrementing at its terminal
// value, so the count never wraps.
module memwait_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] count
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  // Next count: clear has priority over increment
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 4'd0;
    end else if (inc) begin
      count_d = count_q + 4'd1;
    end
  end

  // Count register, cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/main_fsm.sv
// Multicycle processor main controller: Moore FSM sequencing fetch, decode,
// memory, execute and branch steps, with MEM_WAIT extra stall cycles in the
// memory read/write states.
module main_fsm
  import main_fsm_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic [3:0] State
);

  localparam logic [3:0] WAIT_LAST = MEM_WAIT[3:0];

  state_t     state_q;
  state_t     state_d;
  logic [3:0] wait_count;
  logic       in_wait;
  logic       wait_done;
  logic       unused_funct;

  // Only the immediate flag and the S/L bit steer the sequence
  assign unused_funct = ^Funct[4:1];

  assign in_wait   = is_wait_state(state_q);
  assign wait_done = (wait_count == WAIT_LAST);

  // Counter is held at zero outside the memory states, so it reads 0 on entry
  memwait_counter u_memwait_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (!in_wait),
    .inc   (in_wait && !wait_done),
    .count (wait_count)
  );

  // Next-state logic; Op/Funct are only looked at in DECODE and MEMADR
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        case (Op)
          OP_MEM:    state_d = ST_MEMADR;
          OP_DP:     state_d = Funct[5] ? ST_EXECUTEI : ST_EXECUTER;
          OP_BRANCH: state_d = ST_BRANCH;
          default:   state_d = ST_FETCH;  // undefined class executes as a NOP
        endcase
      end
      ST_MEMADR:   state_d = Funct[0] ? ST_MEMREAD : ST_MEMWRITE;
      ST_MEMREAD:  state_d = wait_done ? ST_MEMWB : ST_MEMREAD;
      ST_MEMWB:    state_d = ST_FETCH;
      ST_MEMWRITE: state_d = wait_done ? ST_FETCH : ST_MEMWRITE;
      ST_EXECUTER: state_d = ST_ALUWB;
      ST_EXECUTEI: state_d = ST_ALUWB;
      ST_ALUWB:    state_d = ST_FETCH;
      ST_BRANCH:   state_d = ST_FETCH;
      default:     state_d = ST_FETCH;
    endcase
  end

  // State register; reset returns to FETCH from anywhere
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore output decode; held low while reset is asserted so that the FETCH
  // controls appear as soon as reset releases
  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    if (reset) begin
      case (state_q)
        ST_FETCH: begin
          IRWrite   = 1'b1;
          NextPC    = 1'b1;
          ALUSrcA   = 1'b1;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALU;
        end
        ST_DECODE: begin
          ALUSrcA   = 1'b1;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALU;
        end
        ST_MEMADR: begin
          ALUSrcB = SRCB_IMM;
        end
        ST_MEMREAD: begin
          AdrSrc = 1'b1;
        end
        ST_MEMWB: begin
          ResultSrc = RES_DATA;
          RegW      = 1'b1;
        end
        ST_MEMWRITE: begin
          AdrSrc = 1'b1;
          MemW   = wait_done;  // single strobe in the last stall cycle
        end
        ST_EXECUTER: begin
          ALUOp = 1'b1;
        end
        ST_EXECUTEI: begin
          ALUSrcB = SRCB_IMM;
          ALUOp   = 1'b1;
        end
        ST_ALUWB: begin
          RegW = 1'b1;
        end
        ST_BRANCH: begin
          ALUSrcB   = SRCB_IMM;
          ResultSrc = RES_ALU;
          Branch    = 1'b1;
        end
        default: begin
          IRWrite = 1'b0;
        end
      endcase
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: three instances (MEM_WAIT 0, 2, 3) share
// stimulus; each scenario task checks the instance it targets.
module tb_main_fsm;
  import main_fsm_pkg::*;

  // Output vector: {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp}
  localparam logic [11:0] V_FETCH   = 12'b1_0_1_10_10_1_0_0_0_0;
  localparam logic [11:0] V_DECODE  = 12'b0_0_1_10_10_0_0_0_0_0;
  localparam logic [11:0] V_MEMADR  = 12'b0_0_0_01_00_0_0_0_0_0;
  localparam logic [11:0] V_MEMRD   = 12'b0_1_0_00_00_0_0_0_0_0;
  localparam logic [11:0] V_MEMWB   = 12'b0_0_0_00_01_0_1_0_0_0;
  localparam logic [11:0] V_MEMWR   = 12'b0_1_0_00_00_0_0_0_0_0;
  localparam logic [11:0] V_MEMWR_L = 12'b0_1_0_00_00_0_0_1_0_0;
  localparam logic [11:0] V_EXECR   = 12'b0_0_0_00_00_0_0_0_0_1;
  localparam logic [11:0] V_EXECI   = 12'b0_0_0_01_00_0_0_0_0_1;
  localparam logic [11:0] V_ALUWB   = 12'b0_0_0_00_00_0_1_0_0_0;
  localparam logic [11:0] V_BRANCH  = 12'b0_0_0_01_10_0_0_0_1_0;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] op = 2'b00;
  logic [5:0] funct = 6'b000000;

  logic       ir_write   [3];
  logic       adr_src    [3];
  logic       alu_src_a  [3];
  logic [1:0] alu_src_b  [3];
  logic [1:0] result_src [3];
  logic       next_pc    [3];
  logic       reg_w      [3];
  logic       mem_w      [3];
  logic       branch     [3];
  logic       alu_op     [3];
  logic [3:0] state      [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  main_fsm #(.MEM_WAIT(0)) u_dut0 (
    .clk(clk), .reset(reset), .Op(op), .Funct(funct),
    .IRWrite(ir_write[0]), .AdrSrc(adr_src[0]), .ALUSrcA(alu_src_a[0]),
    .ALUSrcB(alu_src_b[0]), .ResultSrc(result_src[0]), .NextPC(next_pc[0]),
    .RegW(reg_w[0]), .MemW(mem_w[0]), .Branch(branch[0]), .ALUOp(alu_op[0]),
    .State(state[0])
  );

  main_fsm #(.MEM_WAIT(2)) u_dut1 (
    .clk(clk), .reset(reset), .Op(op), .Funct(funct),
    .IRWrite(ir_write[1]), .AdrSrc(adr_src[1]), .ALUSrcA(alu_src_a[1]),
    .ALUSrcB(alu_src_b[1]), .ResultSrc(result_src[1]), .NextPC(next_pc[1]),
    .RegW(reg_w[1]), .MemW(mem_w[1]), .Branch(branch[1]), .ALUOp(alu_op[1]),
    .State(state[1])
  );

  main_fsm #(.MEM_WAIT(3)) u_dut2 (
    .clk(clk), .reset(reset), .Op(op), .Funct(funct),
    .IRWrite(ir_write[2]), .AdrSrc(adr_src[2]), .ALUSrcA(alu_src_a[2]),
    .ALUSrcB(alu_src_b[2]), .ResultSrc(result_src[2]), .NextPC(next_pc[2]),
    .RegW(reg_w[2]), .MemW(mem_w[2]), .Branch(branch[2]), .ALUOp(alu_op[2]),
    .State(state[2])
  );

  function automatic logic [11:0] outs(input int k);
    return {ir_write[k], adr_src[k], alu_src_a[k], alu_src_b[k], result_src[k],
            next_pc[k], reg_w[k], mem_w[k], branch[k], alu_op[k]};
  endfunction

  // Advance one clock; sample point is 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset for two edges; returns with all instances in FETCH
  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    op = 2'b00;
    funct = 6'b000000;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (outs(0) !== 12'h000 || state[0] !== 4'd0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: outs=%b state=%0d, expected outs=0 state=0", i, outs(0), state[0]);
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (outs(0) !== V_FETCH) begin
      errors++;
      $display("FAIL reset_release outs: got %b expected %b", outs(0), V_FETCH);
    end
    checks++;
    if (state[0] !== 4'd0) begin
      errors++;
      $display("FAIL reset_release state: got %0d expected 0", state[0]);
    end
    $display("test_reset done");
  endtask

  task automatic test_exec_imm();
    logic [3:0]  es [5];
    logic [11:0] ev [5];
    es = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
    ev = '{V_FETCH, V_DECODE, V_EXECI, V_ALUWB, V_FETCH};
    do_reset();
    op = 2'b00;
    funct = 6'b101000;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      checks++;
      if (state[0] !== es[i]) begin
        errors++;
        $display("FAIL exec_imm state[%0d]: got %0d expected %0d", i, state[0], es[i]);
      end
      checks++;
      if (outs(0) !== ev[i]) begin
        errors++;
        $display("FAIL exec_imm outs[%0d]: got %b expected %b", i, outs(0), ev[i]);
      end
    end
    $display("test_exec_imm done");
  endtask

  task automatic test_load();
    logic [3:0]  es [8];
    logic [11:0] ev [8];
    es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    ev = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMRD, V_MEMRD, V_MEMWB, V_FETCH};
    do_reset();
    op = 2'b01;
    funct = 6'b000001;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      checks++;
      if (state[1] !== es[i]) begin
        errors++;
        $display("FAIL load_w2 state[%0d]: got %0d expected %0d", i, state[1], es[i]);
      end
      checks++;
      if (outs(1) !== ev[i]) begin
        errors++;
        $display("FAIL load_w2 outs[%0d]: got %b expected %b", i, outs(1), ev[i]);
      end
      // Inputs must be ignored once past MEMADR
      if (i == 3) begin
        op = 2'b10;
        funct = 6'b000000;
      end
    end
    $display("test_load done");
  endtask

  task automatic test_store();
    logic [3:0]  es [8];
    logic [11:0] ev [8];
    int pulses;
    es = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
    ev = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWR, V_MEMWR, V_MEMWR, V_MEMWR_L, V_FETCH};
    pulses = 0;
    do_reset();
    op = 2'b01;
    funct = 6'b100000;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      if (mem_w[2] === 1'b1) pulses++;
      checks++;
      if (state[2] !== es[i]) begin
        errors++;
        $display("FAIL store_w3 state[%0d]: got %0d expected %0d", i, state[2], es[i]);
      end
      checks++;
      if (outs(2) !== ev[i]) begin
        errors++;
        $display("FAIL store_w3 outs[%0d]: got %b expected %b", i, outs(2), ev[i]);
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL store_w3 memw_pulses: got %0d expected 1", pulses);
    end
    $display("test_store done");
  endtask

  task automatic test_branch_undef();
    logic [3:0]  es [6];
    logic [11:0] ev [6];
    int br_cycles;
    es = '{4'd0, 4'd1, 4'd9, 4'd0, 4'd1, 4'd0};
    ev = '{V_FETCH, V_DECODE, V_BRANCH, V_FETCH, V_DECODE, V_FETCH};
    br_cycles = 0;
    do_reset();
    op = 2'b10;
    funct = 6'b100000;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      if (branch[0] === 1'b1) br_cycles++;
      checks++;
      if (state[0] !== es[i]) begin
        errors++;
        $display("FAIL branch_undef state[%0d]: got %0d expected %0d", i, state[0], es[i]);
      end
      checks++;
      if (outs(0) !== ev[i]) begin
        errors++;
        $display("FAIL branch_undef outs[%0d]: got %b expected %b", i, outs(0), ev[i]);
      end
      if (i == 3) begin
        op = 2'b11;
        funct = 6'b111111;
      end
    end
    checks++;
    if (br_cycles !== 1) begin
      errors++;
      $display("FAIL branch_undef branch_cycles: got %0d expected 1", br_cycles);
    end
    $display("test_branch_undef done");
  endtask

  task automatic test_reset_mid_store();
    int pulses;
    pulses = 0;
    do_reset();
    op = 2'b01;
    funct = 6'b000000;
    step();  // DECODE
    step();  // MEMADR
    step();  // first MEMWRITE cycle
    checks++;
    if (state[2] !== 4'd5) begin
      errors++;
      $display("FAIL mid_store reach_memwrite: got %0d expected 5", state[2]);
    end
    if (mem_w[2] === 1'b1) pulses++;
    reset = 1'b0;
    #1;
    checks++;
    if (state[2] !== 4'd0 || outs(2) !== 12'h000) begin
      errors++;
      $display("FAIL mid_store async_reset: state=%0d outs=%b expected state=0 outs=0", state[2], outs(2));
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (mem_w[2] === 1'b1) pulses++;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (state[2] !== 4'd0 || outs(2) !== V_FETCH) begin
      errors++;
      $display("FAIL mid_store release: state=%0d outs=%b expected state=0 outs=%b", state[2], outs(2), V_FETCH);
    end
    op = 2'b00;
    funct = 6'b000000;
    step();
    step();
    checks++;
    if (state[2] !== 4'd6 || outs(2) !== V_EXECR) begin
      errors++;
      $display("FAIL mid_store next_exec: state=%0d outs=%b expected state=6 outs=%b", state[2], outs(2), V_EXECR);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (mem_w[2] === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL mid_store memw_pulses: got %0d expected 0", pulses);
    end
    $display("test_reset_mid_store done");
  endtask

  task automatic test_back_to_back();
    logic [3:0] es [16];
    es = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
           4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd1, 4'd0};
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step();
      checks++;
      if (state[0] !== es[i]) begin
        errors++;
        $display("FAIL b2b state[%0d]: got %0d expected %0d", i, state[0], es[i]);
      end
      checks++;
      if (mem_w[0] !== (i == 12)) begin
        errors++;
        $display("FAIL b2b memw[%0d]: got %b expected %b", i, mem_w[0], (i == 12));
      end
      checks++;
      if (reg_w[0] !== (i == 3 || i == 8)) begin
        errors++;
        $display("FAIL b2b regw[%0d]: got %b expected %b", i, reg_w[0], (i == 3 || i == 8));
      end
      case (i)
        0:  begin op = 2'b00; funct = 6'b000000; end
        4:  begin op = 2'b01; funct = 6'b000001; end
        9:  begin op = 2'b01; funct = 6'b000000; end
        13: begin op = 2'b11; funct = 6'b000000; end
        default: ;
      endcase
    end
    $display("test_back_to_back done");
  endtask

  initial begin
    test_reset();
    test_exec_imm();
    test_load();
    test_store();
    test_branch_undef();
    test_reset_mid_store();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports are named clk and reset, and reset polarity and synchronicity are fixed.
REQ-002 Parameter MEM_WAIT, default 0: extra wait cycles held in MEMREAD and MEMWRITE; legal range 0..15.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  async active-low reset.
REQ-005 Op  in  2  instruction class: 00 data-processing, 01 memory, 10 branch, 11 undefined.
REQ-006 Funct  in  6  instruction Funct field; Funct[5] = immediate flag I, Funct[0] = S/L bit.
REQ-007 IRWrite  out  1  instruction register load enable.
REQ-008 AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result.
REQ-009 ALUSrcA  out  1  ALU A select: 0 = register, 1 = PC.
REQ-010 ALUSrcB  out  2  ALU B select: 00 = register, 01 = immediate, 10 = constant 4.
REQ-011 ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALU result.
REQ-012 NextPC  out  1  PC update enable.
REQ-013 RegW  out  1  register write request, feeds conditional logic RegW.
REQ-014 MemW  out  1  memory write request, feeds conditional logic MemW.
REQ-015 Branch  out  1  branch request, ORed downstream into PCS.
REQ-016 ALUOp  out  1  1 = ALU decoder uses Funct; 0 = forced ADD.
REQ-017 State  out  4  current state encoding, for debug.

Function
REQ-018 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH; all outputs decode from state and the wait counter only.
REQ-019 The block SHALL drive any output not listed for a state to 0.
REQ-020 FETCH SHALL drive IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, AdrSrc=0, ALUOp=0, and SHALL always transition to DECODE.
REQ-021 DECODE SHALL drive ALUSrcA=1, ALUSrcB=10, ResultSrc=10, and SHALL transition as follows: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECUTER; Op=00 with Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> FETCH, treated as a NOP with no write strobes.
REQ-022 MEMADR SHALL drive ALUSrcA=0, ALUSrcB=01, ALUOp=0, and SHALL transition to MEMREAD when Funct[0]=1, otherwise to MEMWRITE.
REQ-023 MEMREAD SHALL drive AdrSrc=1, ResultSrc=00, and SHALL transition to MEMWB after 1+MEM_WAIT cycles.
REQ-024 MEMWB SHALL drive ResultSrc=01, RegW=1, and SHALL transition to FETCH.
REQ-025 MEMWRITE SHALL drive AdrSrc=1, ResultSrc=00, SHALL assert MemW only in its final cycle (exactly one MemW pulse per store), and SHALL transition to FETCH after 1+MEM_WAIT cycles.
REQ-026 EXECUTER SHALL drive ALUSrcA=0, ALUSrcB=00, ALUOp=1; EXECUTEI SHALL drive ALUSrcA=0, ALUSrcB=01, ALUOp=1; both SHALL transition to ALUWB.
REQ-027 ALUWB SHALL drive ResultSrc=00, RegW=1, and SHALL transition to FETCH.
REQ-028 BRANCH SHALL drive ALUSrcA=0, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1, and SHALL transition to FETCH.
REQ-029 The wait counter SHALL be 4 bits, SHALL load 0 on entry to MEMREAD or MEMWRITE, SHALL increment each cycle in those states, and SHALL release the state when it equals MEM_WAIT; it never wraps.
REQ-030 Op and Funct SHALL be sampled only in DECODE and MEMADR; changes in other states SHALL have no effect.
REQ-031 Per-instruction latency SHALL be: load 5+MEM_WAIT, store 4+MEM_WAIT, data-processing 4, branch 3, undefined 2 cycles.

Reset
REQ-032 Asserting reset SHALL immediately set the state to FETCH and the counter to 0, including mid-instruction; no write strobe SHALL be pending afterwards.
REQ-033 While reset is low, all outputs SHALL be 0 and State SHALL read the FETCH encoding.
REQ-034 On the first rising edge after reset deasserts, the block SHALL be in FETCH with FETCH outputs already driven.

Structure
REQ-035 A shared package SHALL hold the state enum typedef (4 bits), the ALUSrcB and ResultSrc encoding constants, and the Op class constants.
REQ-036 The wait counter SHALL be a sub-module named memwait_counter; everything else SHALL live in main_fsm.

Verification
REQ-037 Reset sequence: hold reset low 3 cycles, then release -> all outputs 0 during reset; FETCH outputs (IRWrite=1, NextPC=1) in the first cycle after release.
REQ-038 Op=00, Funct=6'b101000, MEM_WAIT=0 -> state sequence FETCH, DECODE, EXECUTEI, ALUWB, FETCH, with RegW=1 only in ALUWB.
REQ-039 Op=01, Funct[0]=1, MEM_WAIT=2 -> MEMREAD held 3 cycles, MEMWB 1 cycle, total 7 cycles back to FETCH.
REQ-040 Op=01, Funct[0]=0, MEM_WAIT=3 -> exactly one MemW pulse, in the 4th MEMWRITE cycle.
REQ-041 Op=10 -> Branch=1 for one cycle in BRANCH; Op=11 -> return to FETCH from DECODE with no RegW, MemW or Branch.
REQ-042 Assert reset during MEMWRITE with MEM_WAIT=3 -> MemW never asserted; state is FETCH after release.
